// File: rtl/cbc_feistel_decrypt.sv
// cbc_feistel_decrypt: CBC-mode 5-round Feistel block decryptor driven by a chaotic S-box
module key_schedule_5r #(
  parameter int KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                key_tvalid,
  input  logic [KEY_SIZE-1:0] key,
  output logic                key_valid,
  output logic [KEY_SIZE-1:0] k0,
  output logic [KEY_SIZE-1:0] k1,
  output logic [KEY_SIZE-1:0] k2,
  output logic [KEY_SIZE-1:0] k3,
  output logic [KEY_SIZE-1:0] k4
);
  function automatic logic [KEY_SIZE-1:0] nxt(input logic [KEY_SIZE-1:0] k);
    return {k[KEY_SIZE-30:0], k[KEY_SIZE-1:KEY_SIZE-29]} ^ (k >> 7);
  endfunction
  // expand the master key into five subkeys, each derived from the previous one
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      key_valid <= 1'b0;
      k0 <= '0;
      k1 <= '0;
      k2 <= '0;
      k3 <= '0;
      k4 <= '0;
    end else if (key_tvalid) begin
      key_valid <= 1'b1;
      k0 <= key;
      k1 <= nxt(key);
      k2 <= nxt(nxt(key));
      k3 <= nxt(nxt(nxt(key)));
      k4 <= nxt(nxt(nxt(nxt(key))));
    end
endmodule

module cbc_feistel_decrypt #(
  parameter int ROUND      = 5,
  parameter int KEY_SIZE   = 128,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sbox_valid,
  input  logic [7:0]            sbox_out,
  input  logic                  key_tvalid,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic                  decr_tvalid,
  input  logic                  first_block,
  input  logic [BLOCK_SIZE-1:0] ciphertext,
  input  logic [BLOCK_SIZE-1:0] iv,
  output logic                  decr_tready,
  output logic                  decr_valid,
  output logic [BLOCK_SIZE-1:0] plaintext
);
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_ROUND, S_DONE} state_t;
  state_t                state;
  logic [7:0]            sbox [256];
  logic [7:0]            cnt;
  logic                  loaded;
  logic                  reset_n;
  logic                  key_valid;
  logic [KEY_SIZE-1:0]   k0, k1, k2, k3, k4;
  logic [KEY_SIZE-1:0]   lft, rgt, kr, y, z, f;
  logic [2:0]            rnd;
  logic [BLOCK_SIZE-1:0] prev, last_ct;
  assign reset_n = ~reset;
  key_schedule_5r #(.KEY_SIZE(KEY_SIZE)) u_ks (
    .clk(clk),
    .reset_n(reset_n),
    .key_tvalid(key_tvalid),
    .key(key),
    .key_valid(key_valid),
    .k0(k0),
    .k1(k1),
    .k2(k2),
    .k3(k3),
    .k4(k4)
  );
  // table storage is deliberately unreset; it is refilled after every reset
  always_ff @(posedge clk)
    if (sbox_valid && !loaded) sbox[cnt] <= sbox_out;
  // fill pointer and lock flag; the table locks after entry 255
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (sbox_valid && !loaded) begin
      cnt    <= cnt + 8'd1;
      loaded <= cnt == 8'hff;
    end
  // inverse round function on the left half with the subkey of the current round
  always_comb begin
    kr = rnd == 3'd4 ? k4 : rnd == 3'd3 ? k3 : rnd == 3'd2 ? k2 : rnd == 3'd1 ? k1 : k0;
    y  = lft ^ kr;
    z  = '0;
    for (int b = 0; b < KEY_SIZE / 8; b++) z[8*b +: 8] = sbox[y[8*b +: 8]];
    f  = z ^ {z[KEY_SIZE-33:0], z[KEY_SIZE-1:KEY_SIZE-32]};
  end
  // control FSM: accept, five reverse rounds, then chain and publish the plaintext
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= S_WAIT;
      decr_tready <= 1'b0;
      decr_valid  <= 1'b0;
      plaintext   <= '0;
      lft         <= '0;
      rgt         <= '0;
      rnd         <= '0;
      prev        <= '0;
      last_ct     <= '0;
    end else begin
      decr_valid <= 1'b0;
      if (state == S_DONE) begin
        plaintext  <= {lft, rgt} ^ prev;
        decr_valid <= 1'b1;
      end
      if (!(loaded && key_valid)) begin
        state       <= S_WAIT;
        decr_tready <= 1'b0;
      end else if (decr_tready && decr_tvalid) begin
        state       <= S_ROUND;
        decr_tready <= 1'b0;
        lft         <= ciphertext[BLOCK_SIZE-1:KEY_SIZE];
        rgt         <= ciphertext[KEY_SIZE-1:0];
        rnd         <= 3'(ROUND - 1);
        prev        <= first_block ? iv : last_ct;
        last_ct     <= ciphertext;
      end else if (state == S_ROUND) begin
        lft <= rgt ^ f;
        rgt <= lft;
        rnd <= rnd - 3'd1;
        if (rnd == 3'd0) begin
          state       <= S_DONE;
          decr_tready <= 1'b1;
        end
      end else begin
        state       <= S_IDLE;
        decr_tready <= 1'b1;
      end
    end
endmodule

// File: doc/cbc_feistel_decrypt.md
# cbc_feistel_decrypt

CBC-mode Feistel block decryptor, the inverse of `cbc_feistel_encrypt` in the chaos-based image cipher. It reverses the 5-round, 256-bit Feistel network using the same chaotic S-box stream and the same `key_schedule_5r` subkeys, applying the round keys in reverse order. It then XORs the result with the chaining value (IV or previous ciphertext) to recover plaintext. It sits on the receive side, one block per 6 cycles.

## Interface
- `ROUND`, 5, Feistel rounds; the design supports only 5, matching the `key_schedule_5r` outputs.
- `KEY_SIZE`, 128, master key and subkey width; equals half-block width.
- `BLOCK_SIZE`, 256, block width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sbox_valid`  in  1  qualifies `sbox_out`.
- `sbox_out`  in  8  next S-box entry, delivered in index order 0..255.
- `key_tvalid`  in  1  loads `key` into the internal `key_schedule_5r`.
- `key`  in  KEY_SIZE  master key.
- `decr_tvalid`  in  1  ciphertext block offered.
- `first_block`  in  1  qualified by `decr_tvalid`; when high, chain with `iv`.
- `ciphertext`  in  BLOCK_SIZE  block to decrypt.
- `iv`  in  BLOCK_SIZE  initialisation vector, sampled only when `first_block` is high.
- `decr_tready`  out  1  block can accept a ciphertext.
- `decr_valid`  out  1  one-cycle pulse; `plaintext` is valid.
- `plaintext`  out  BLOCK_SIZE  recovered block; held until the next result.

## Operation
- **S-box load:**
  - An 8-bit counter plus a loaded flag write `sbox[cnt] <= sbox_out` on each `sbox_valid`.
  - After entry 255 the flag sets and the table locks. Further `sbox_valid` is ignored until reset.
- **Subkeys:**
  - `key_schedule_5r` is instantiated with `reset_n = ~reset` and supplies K0..K4.
  - `key_valid` must be high before blocks are accepted.
- **Round function:**
  - `F(x,k)`: `y = x ^ k`.
  - Substitute each of the 16 bytes: `z_b = sbox[y_b]`.
  - `F = z ^ rotl(z,32)`.
- **Encryptor definition (for reference):**
  - L=`blk[255:128]`, R=`blk[127:0]`.
  - Round i=0..4: `L'=R`, `R'=L^F(R,K_i)`.
  - Output `{L5,R5}`, with no final swap.
- **Decrypt:**
  - Load `{L,R} <= ciphertext`.
  - For i=4 down to 0, one round per cycle: `L' = R ^ F(L,K_i)`, `R' = L`.
- **Chaining:**
  - `plaintext = {L0,R0} ^ prev`.
  - On accept, `prev_next` = `iv` if `first_block`, else the stored previous ciphertext.
  - The stored previous ciphertext is updated to the accepted ciphertext.
- **FSM:**
  - WAIT: until sbox loaded and `key_valid`, then go to IDLE.
  - IDLE: `decr_tready`=1. On `decr_tvalid`, capture and go to ROUND with round index r=4.
  - ROUND: one round per cycle, r decrements. After r=0, go to DONE.
  - DONE: register `plaintext`, pulse `decr_valid`, return to IDLE. `decr_tready`=1 in DONE, so acceptance there goes directly to ROUND.
- `key_tvalid` outside WAIT/IDLE is a protocol violation; the result for the in-flight block is undefined. When `key_valid` drops, the FSM returns to WAIT.
- If the first block after reset has `first_block`=0, the block chains with the stored previous ciphertext, which resets to 0.

## Timing
- Reset values:
  - `decr_tready`=0, `decr_valid`=0, `plaintext`=0.
  - FSM=WAIT, sbox counter and loaded flag=0, stored previous ciphertext=0.
  - Table contents are not reset and must be reloaded.
- Reset mid-load or mid-decrypt aborts immediately. No `decr_valid` follows for the aborted block.
- Accept at edge T (`decr_tvalid & decr_tready`). Rounds occupy edges T+1..T+5. `decr_valid`=1 and `plaintext` update after edge T+6: latency 6 cycles.
- A new accept is possible in the DONE cycle, giving sustained throughput of one block per 6 cycles.
- `decr_tvalid` while `decr_tready`=0 is ignored; no inputs are captured.
- `decr_tready` is low during WAIT and ROUND.
- The S-box can finish loading and `key_valid` can rise in the same cycle; IDLE follows on the next edge.

## Test plan
- **Zero vector:** identity S-box (s[i]=i), key=0, first block ct=0, iv=0 -> `plaintext`=0, with `decr_valid` exactly 6 cycles after accept.
- **IV path:** same setup, ct=0, iv=all-ones, `first_block`=1 -> `plaintext`=all-ones.
- **Chaining:** 4 random blocks encrypted by the bench model (random S-box permutation, random key, iv) and fed back-to-back, `first_block` on block 0 only -> all 4 plaintexts match. Accepts land in DONE cycles, so accepts are spaced 6 cycles apart.
- **Handshake:** hold `decr_tvalid` high with changing ciphertext during ROUND -> only the value present at the accept edge is decrypted; `decr_tready` is low for the 5 ROUND cycles.
- **Readiness gating:** load only 255 S-box bytes plus a key -> `decr_tready` stays 0. The 256th byte raises it one cycle later; a 257th byte leaves the table unchanged.
- **Reset mid-decrypt:** assert `reset` in round 2 -> outputs return to 0 immediately, no `decr_valid` follows, and `decr_tready` stays 0 until S-box and key are reloaded.
